// File: rtl/adat_rx_adat_pkg.sv
// adat_rx_adat_pkg: ADAT frame geometry, TX state type and frame layout helper
package adat_rx_adat_pkg;

   localparam int ADAT_FRAME_BITS  = 256;
   localparam int ADAT_SYNC_ZEROS  = 10;
   localparam int ADAT_NIBBLES     = 48;
   localparam int ADAT_CHANNELS    = 8;
   localparam int ADAT_SAMPLE_BITS = 24;

   typedef enum logic {AdatTxState_Idle, AdatTxState_Run} AdatTxState;

   typedef struct packed {
      logic [0:ADAT_CHANNELS-1][ADAT_SAMPLE_BITS-1:0] ch;
      logic [3:0]                                     user;
   } adat_frame_t;

   // Frame bit b lands at vector index b: sync zeros, '1', U3..U0, '1', then 48 nibbles each followed by '1'
   function automatic logic [ADAT_FRAME_BITS-1:0] adat_build_frame(input adat_frame_t f);
      logic [ADAT_FRAME_BITS-1:0] v;
      v = '0;
      v[ADAT_SYNC_ZEROS] = 1'b1;
      for (int i = 0; i < 4; i++) v[11 + i] = f.user[3 - i];
      v[15] = 1'b1;
      for (int k = 0; k < ADAT_NIBBLES; k++) begin
         for (int j = 0; j < 4; j++) v[16 + 5 * k + j] = f.ch[k / 6][(5 - k % 6) * 4 + 3 - j];
         v[20 + 5 * k] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/adat_tx_nrzi_encoder.sv
// adat_tx_nrzi_encoder: NRZI line flop, toggles on each strobed '1'
module adat_tx_nrzi_encoder (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_bit_en,
   input  logic i_bit,
   output logic o_line
);

   // Toggle the line for a '1', hold for a '0'; line idles low out of reset
   always_ff @(posedge i_clk)
      if (!i_rst) o_line <= 1'b0;
      else if (i_bit_en && i_bit) o_line <= ~o_line;

endmodule

// File: rtl/adat_tx_frame_serializer.sv
// adat_tx_frame_serializer: buffers 8x24-bit frames and emits NRZI ADAT; ADAT_TX_REPEAT_ON_UNDERRUN_EN repeats the last frame on underrun
module adat_tx_frame_serializer
   import adat_rx_adat_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_bit_en,
   input  logic [23:0] i_channels [0:7],
   input  logic [3:0]  i_user_bits,
   input  logic        i_valid,
   output logic        o_ready,
   output logic        o_adat,
   output logic        o_frame_start,
   output logic        o_underrun,
   output logic        o_active
);

   AdatTxState                 state;
   logic [7:0]                 cnt;
   adat_frame_t                hold, act, din;
   logic                       hold_full, act_valid;
   logic                       hs, emit, boundary, cur_bit;
   logic [ADAT_FRAME_BITS-1:0] frame_vec;

   // Gather the unpacked input samples into one frame word
   always_comb begin
      din.user = i_user_bits;
      for (int c = 0; c < ADAT_CHANNELS; c++) din.ch[c] = i_channels[c];
   end

   assign hs        = i_valid && !hold_full;
   assign o_ready   = !hold_full;
   assign emit      = i_bit_en && act_valid;
   assign boundary  = emit && cnt == 8'hFF;
   assign frame_vec = adat_build_frame(act);
   assign cur_bit   = frame_vec[cnt];
   assign o_active  = state == AdatTxState_Run;

   // Buffer handoff, bit counter and the registered frame/underrun strobes
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state         <= AdatTxState_Idle;
         cnt           <= '0;
         hold          <= '0;
         act           <= '0;
         hold_full     <= 1'b0;
         act_valid     <= 1'b0;
         o_frame_start <= 1'b0;
         o_underrun    <= 1'b0;
      end else begin
         o_frame_start <= emit && cnt == 8'd0;
         o_underrun    <= boundary && !hs && !hold_full;
         if (emit) begin
            cnt   <= cnt + 8'd1;
            state <= AdatTxState_Run;
         end
         if (!act_valid && hold_full) begin
            act       <= hold;
            act_valid <= 1'b1;
            hold_full <= 1'b0;
         end else if (boundary) begin
            if (hold_full) begin
               act       <= hold;
               hold_full <= 1'b0;
            end else if (hs) act <= din;
`ifdef ADAT_TX_REPEAT_ON_UNDERRUN_EN
            else act <= act;
`else
            else act <= '0;
`endif
         end
         if (hs && !boundary) begin
            hold      <= din;
            hold_full <= 1'b1;
         end
      end
   end

   adat_tx_nrzi_encoder u_nrzi (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_bit_en(emit),
      .i_bit   (cur_bit),
      .o_line  (o_adat)
   );

endmodule
